seg7_scan_paged: RTL

//  Time-multiplexed driver for a common-anode multi-digit 7-segment display fed with ASCII bytes.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_ascii_decode.sv | 13 +
 rtl/seg7_scan_paged.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants and the ASCII-to-segment decoder for the
// paged 7-segment scanner.
//   Glyphs are 7 bits ordered g..a (bit 6 = g, bit 0 = a), active-low, so a
//   cleared bit lights the segment on a common-anode display.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Map one ASCII byte to its glyph; anything without a glyph is blank, never '0'.
  function automatic logic [6:0] ascii_to_seg(input logic [7:0] code);
    logic [6:0] seg;
    case (code)
      8'h30:        seg = 7'b1000000;
      8'h31:        seg = 7'b1111001;
      8'h32:        seg = 7'b0100100;
      8'h33:        seg = 7'b0110000;
      8'h34:        seg = 7'b0011001;
      8'h35:        seg = 7'b0010010;
      8'h36:        seg = 7'b0000010;
      8'h37:        seg = 7'b1111000;
      8'h38:        seg = 7'b0000000;
      8'h39:        seg = 7'b0010000;
      8'h41, 8'h61: seg = SEG_HEX_A;
      8'h42, 8'h62: seg = SEG_HEX_B;
      8'h43, 8'h63: seg = SEG_HEX_C;
      8'h44, 8'h64: seg = SEG_HEX_D;
      8'h45, 8'h65: seg = SEG_HEX_E;
      8'h46, 8'h66: seg = SEG_HEX_F;
      8'h2D:        seg = SEG_DASH;
      8'h20:        seg = SEG_BLANK;
      default:      seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_ascii_decode.sv
// seg7_ascii_decode: combinational ASCII-to-glyph decoder.
//   code_i  in  8  ASCII byte
//   seg_o   out 7  glyph g..a, active-low
module seg7_ascii_decode
  import seg7_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = ascii_to_seg(code_i);

endmodule

// File: rtl/seg7_scan_paged.sv
// seg7_scan_paged: time-multiplexed common-anode 7-segment driver with
// NUM_PAGES shadow pages of ASCII characters.
//   clk, rst_n   clock, asynchronous active-low reset
//   load         one-cycle strobe writing load_data into page load_page
//   load_page    target page (out-of-range values ignored)
//   load_data    ASCII bytes, digit i in [8i+7:8i]
//   page_sel     requested page, adopted only at a frame boundary (out of range -> 0)
//   dp_in        per-digit decimal point request, active-high
//   num, dp      registered glyph / decimal point, active-low
//   anode        registered digit enables, active-low, blanked at each slot start
//   frame_start  registered pulse when digit 0's slot begins
module seg7_scan_paged
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int NUM_PAGES    = 2,
  parameter  int SCAN_DIV     = 50000,
  parameter  int BLANK_CYCLES = 16,
  localparam int PAGE_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [PAGE_W-1:0]       load_page,
  input  logic [NUM_DIGITS*8-1:0] load_data,
  input  logic [PAGE_W-1:0]       page_sel,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              num,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  // One extra bit so the limits themselves are representable.
  localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYCLES);
  localparam logic [PAGE_W:0]  PAGE_LIM  = (PAGE_W + 1)'(NUM_PAGES);

  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [NUM_PAGES-1:0][NUM_DIGITS-1:0][7:0] shadow_q, shadow_d;
  logic [6:0]            num_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] anode_d;
  logic                  frame_start_d;

  logic       tick_s;
  logic       load_ok_s;
  logic       sel_ok_s;
  logic [6:0] glyph_s;

  assign tick_s    = (pre_cnt_q == CNT_LAST);
  assign load_ok_s = load && ({1'b0, load_page} < PAGE_LIM);
  assign sel_ok_s  = ({1'b0, page_sel} < PAGE_LIM);

  seg7_ascii_decode u_decode (
    .code_i (shadow_q[page_q][idx_q]),
    .seg_o  (glyph_s)
  );

  // Next-state logic for the scan counters, page register, shadow pages and outputs.
  always_comb begin
    pre_cnt_d     = pre_cnt_q;
    idx_d         = idx_q;
    page_d        = page_q;
    shadow_d      = shadow_q;
    num_d         = glyph_s;
    dp_d          = ~dp_in[idx_q];
    anode_d       = {NUM_DIGITS{1'b1}};
    frame_start_d = (idx_q == '0) && (pre_cnt_q == '0);

    if (tick_s) begin
      pre_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        // Page only changes between frames so a frame never mixes pages.
        page_d = sel_ok_s ? page_sel : '0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        page_d = page_q;
      end
    end else begin
      pre_cnt_d = pre_cnt_q + CNT_W'(1);
    end

    // Loads are not frame-held: a write to the shown page appears immediately.
    if (load_ok_s) begin
      shadow_d[load_page] = load_data;
    end else begin
      shadow_d = shadow_q;
    end

    // Dead time at the start of each slot lets the previous digit turn off fully.
    if ({1'b0, pre_cnt_q} < BLANK_LIM) begin
      anode_d = {NUM_DIGITS{1'b1}};
    end else begin
      anode_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q   <= '0;
      idx_q       <= '0;
      page_q      <= '0;
      shadow_q    <= {(NUM_PAGES * NUM_DIGITS){8'h20}};
      num         <= SEG_BLANK;
      dp          <= 1'b1;
      anode       <= {NUM_DIGITS{1'b1}};
      frame_start <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      shadow_q    <= shadow_d;
      num         <= num_d;
      dp          <= dp_d;
      anode       <= anode_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
